// File: rtl/t03_wishbone_subordinate_if.sv
// Wishbone classic-cycle bus bundle between the t03 manager and a subordinate.
// The manager drives the request side; the subordinate drives data and status.
interface t03_wishbone_subordinate_if;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic [3:0]  SEL_I;
    logic        WE_I;
    logic        STB_I;
    logic        CYC_I;
    logic [31:0] DAT_O;
    logic        ACK_O;
    logic        BUSY_O;

    modport master (
        output ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
        input  DAT_O, ACK_O, BUSY_O
    );

    modport slave (
        input  ADR_I, DAT_I, SEL_I, WE_I, STB_I, CYC_I,
        output DAT_O, ACK_O, BUSY_O
    );
endinterface

// File: rtl/t03_wishbone_subordinate.sv
// Wishbone classic subordinate in front of a byte-writable scratch memory.
// Adds WAIT_STATES wait cycles, acknowledges misses, and supports abort in WAIT.
module t03_wishbone_subordinate #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 2
) (
    input logic CLK,
    input logic RST,
    t03_wishbone_subordinate_if.slave bus
);
    localparam int          IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);
    localparam logic [31:0] MISS = 32'hBAD1_BAD1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;

    logic [31:0] adr_q, dat_q;
    logic [3:0]  sel_q;
    logic        we_q;

    logic [31:0] req_adr, req_dat;
    logic [3:0]  req_sel;
    logic        req_we;
    logic [32:0] diff;
    logic        hit;
    logic [IW-1:0] idx;
    logic        enter_ack;
    logic        wr_en;

    logic [31:0] mem [DEPTH];

    logic [31:0] dat_o_q;
    logic        ack_q;
    logic        busy_q;

    // In IDLE the request is still on the bus; afterwards use the latched copy.
    always_comb begin
        if (state_q == S_IDLE) begin
            req_adr = bus.ADR_I;
            req_dat = bus.DAT_I;
            req_sel = bus.SEL_I;
            req_we  = bus.WE_I;
        end else begin
            req_adr = adr_q;
            req_dat = dat_q;
            req_sel = sel_q;
            req_we  = we_q;
        end
    end

    // Window decode; bit 32 of the difference flags an address below BASE_ADDR.
    always_comb begin
        diff = {1'b0, req_adr} - {1'b0, BASE_ADDR};
        hit  = !diff[32] && (diff[31:0] < SPAN);
        idx  = diff[IW+1:2];
    end

    // Next-state logic: accept, count down wait states, abort, single ACK cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.STB_I && bus.CYC_I) begin
                    accept  = 1'b1;
                    cnt_d   = WS;
                    state_d = (WS == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!(bus.STB_I && bus.CYC_I)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign enter_ack = (state_d == S_ACK);
    assign wr_en     = enter_ack && req_we && hit;

    // FSM state and wait counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request at accept so later bus changes are ignored.
    always_ff @(posedge CLK) begin
        if (RST) begin
            adr_q <= 32'd0;
            dat_q <= 32'd0;
            sel_q <= 4'd0;
            we_q  <= 1'b0;
        end else if (accept) begin
            adr_q <= bus.ADR_I;
            dat_q <= bus.DAT_I;
            sel_q <= bus.SEL_I;
            we_q  <= bus.WE_I;
        end
    end

    // Registered outputs; read data is only non-zero in a read ACK cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            dat_o_q <= 32'd0;
        end else begin
            ack_q  <= enter_ack;
            busy_q <= (state_d != S_IDLE);
            if (enter_ack && !req_we) begin
                dat_o_q <= hit ? mem[idx] : MISS;
            end else begin
                dat_o_q <= 32'd0;
            end
        end
    end

    // Byte-lane write commit on the edge entering ACK; reset blocks it.
    always_ff @(posedge CLK) begin
        if (!RST && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) begin
                    mem[idx][8*b +: 8] <= req_dat[8*b +: 8];
                end
            end
        end
    end

    assign bus.DAT_O  = dat_o_q;
    assign bus.ACK_O  = ack_q;
    assign bus.BUSY_O = busy_q;
endmodule
